dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the CPU data-memory port: the other end of the requests
//  the controller issues through its DCache_WE / ST_Size / LD_Size outputs.
//  Accepts one load/store per valid/ready handshake and holds it in a word-wide
//  internal SRAM model. Applies store byte-lane shifting and load extraction with
//  sign/zero extension, then returns one response per request after a fixed latency.
// PARAMETERS
//  ADDR_WIDTH  14  word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//  LATENCY     2   cycles from accept edge to resp_valid for aligned requests (>=1)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  reset            in   1   synchronous, active-low reset
//  req_valid        in   1   request present
//  req_ready        out  1   responder can accept; handshake = req_valid & req_ready
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data, unshifted (byte in [7:0], half in [15:0])
//  req_we           in   4   store request if any bit set (4'b1111 from control), else load
//  req_size         in   3   func3: load 000 LB,001 LH,010 LW,100 LBU,101 LHU; store uses [1:0]
//  resp_valid       out  1   one-cycle response pulse, one per accepted request
//  resp_rdata       out  32  extended load data; 0 for stores and errors
//  resp_err         out  1   misaligned/illegal request; qualified by resp_valid
// BEHAVIOUR
//  - Reset (reset==0 at edge): state IDLE, req_ready=0 while reset low, resp_valid=0,
//    resp_rdata=0, resp_err=0, counter=0. SRAM contents NOT reset.
//  - FSM: IDLE -> (accept, aligned) WAIT or RESP if LATENCY==1; IDLE -> (accept, err) RESP;
//    WAIT: counter counts LATENCY-1 cycles then RESP; RESP -> IDLE unconditionally.
//  - req_ready=1 only in IDLE with reset high; req_valid in WAIT/RESP ignored (no queue).
//  - Request fields latched at accept edge; later req_* changes have no effect.
//  - Aligned response: resp_valid high exactly in cycle accept+LATENCY; error response
//    in cycle accept+1. Throughput: one request per LATENCY+1 (or 2) cycles.
//  - resp_rdata/resp_err valid only while resp_valid=1; driven to 0 otherwise.
//  - Index = req_addr[ADDR_WIDTH+1:2]; upper address bits ignored (aliasing wrap).
//  - Error: half with addr[0]=1; word with addr[1:0]!=0; store size[1:0]==11;
//    load size 011/110/111. Errors never touch SRAM; resp_err=1, resp_rdata=0.
//  - Store: write commits on accept edge. Byte: lane addr[1:0] <= wdata[7:0];
//    half: lanes {addr[1],1}/{addr[1],0} <= wdata[15:0]; word: all lanes. Other lanes kept.
//  - Load: word read at accept edge (sees prior committed stores); lane sel by addr[1:0];
//    LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW raw.
//  - Reset low mid-WAIT/RESP: request dropped, no resp_valid; an already-committed store
//    stays written. req_ready=1 in the first cycle after reset returns high.
//  - Simultaneous resp_valid and new req_valid: not accepted that cycle (ready=0).
// TESTING
//  1 reset low 3 cycles, req_valid=1 -> req_ready=0, resp_valid=0; first cycle high -> req_ready=1
//  2 SW 0xDEADBEEF @0x10, then LW @0x10 -> each resp exactly LATENCY cycles after accept;
//    LW rdata=0xDEADBEEF, resp_err=0
//  3 after (2): LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD;
//    LHU @0x12 -> 0x0000DEAD; LB @0x10 -> 0xFFFFFFEF
//  4 SB wdata=0x12345655 @0x11, SH wdata=0xAAAA7777 @0x12, LW @0x10 -> 0x777755EF
//  5 LW @0x12 and SH @0x13 -> resp_valid at accept+1, resp_err=1, rdata=0; LW @0x10 still 0x777755EF
//  6 LW accepted, reset low 1 cycle in WAIT -> no resp_valid; ready=1 next cycle; LW @0x10 -> 0x777755EF
//  7 LATENCY=1 build: back-to-back LW with req_valid held -> accepts every 2nd cycle, rdata correct

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake against a word-wide SRAM model
// and returns one response per request after a fixed latency (errors after one cycle).
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    logic [31:0]        mem [DEPTH];

    logic                  accept_c;
    logic                  is_store_c;
    logic                  req_err_c;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic [31:0]           rd_word_c;
    logic [7:0]            ld_byte_c;
    logic [15:0]           ld_half_c;
    logic [31:0]           ld_data_c;
    logic [31:0]           st_data_c;
    logic [3:0]            be_c;
    logic                  unused_addr_c;

    assign req_ready     = reset && (state_q == S_IDLE);
    assign accept_c      = req_valid && req_ready;
    assign is_store_c    = |req_we;
    assign idx_c         = req_addr[ADDR_WIDTH+1:2];
    assign unused_addr_c = ^req_addr[31:ADDR_WIDTH+2];
    assign rd_word_c     = mem[idx_c];
    assign ld_byte_c     = 8'(rd_word_c >> {req_addr[1:0], 3'b000});
    assign ld_half_c     = 16'(rd_word_c >> {req_addr[1], 4'b0000});

    // Request decode: alignment/size errors, store lane enables, load extraction
    always_comb begin
        req_err_c = 1'b0;
        ld_data_c = '0;
        st_data_c = '0;
        be_c      = '0;
        if (is_store_c) begin
            case (req_size[1:0])
                2'b00: begin
                    be_c      = 4'b0001 << req_addr[1:0];
                    st_data_c = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    if (req_addr[0]) begin
                        req_err_c = 1'b1;
                    end else begin
                        be_c      = req_addr[1] ? 4'b1100 : 4'b0011;
                        st_data_c = {2{req_wdata[15:0]}};
                    end
                end
                2'b10: begin
                    if (req_addr[1:0] != 2'b00) begin
                        req_err_c = 1'b1;
                    end else begin
                        be_c      = 4'b1111;
                        st_data_c = req_wdata;
                    end
                end
                default: req_err_c = 1'b1;
            endcase
        end else begin
            case (req_size)
                3'b000: ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
                3'b001: begin
                    if (req_addr[0]) req_err_c = 1'b1;
                    else             ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
                end
                3'b010: begin
                    if (req_addr[1:0] != 2'b00) req_err_c = 1'b1;
                    else                        ld_data_c = rd_word_c;
                end
                3'b100: ld_data_c = {24'h000000, ld_byte_c};
                3'b101: begin
                    if (req_addr[0]) req_err_c = 1'b1;
                    else             ld_data_c = {16'h0000, ld_half_c};
                end
                default: req_err_c = 1'b1;
            endcase
        end
    end

    // Next-state and response staging; results captured at accept, released on entering RESP
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    data_d = ld_data_c;
                    err_d  = req_err_c;
                    cnt_d  = '0;
                    if (req_err_c || (LATENCY == 1)) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = ld_data_c;
                        resp_err_d   = req_err_c;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 2)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = data_q;
                    resp_err_d   = err_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // SRAM contents survive reset; stores commit on the accept edge
    always_ff @(posedge clk) begin
        if (accept_c && is_store_c && !req_err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: cycle-indexed reference model with per-cycle compare, directed
// literal cases, randomized traffic with reset pulses, and a LATENCY=1 instance.
module tb_dmem_responder;
    localparam int unsigned AW  = 14;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_we;
    logic [2:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        r1_valid, r1_ready;
    logic [31:0] r1_addr, r1_wdata;
    logic [3:0]  r1_we;
    logic [2:0]  r1_size;
    logic        r1_resp_valid, r1_resp_err;
    logic [31:0] r1_resp_rdata;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err));

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(r1_valid), .req_ready(r1_ready),
        .req_addr(r1_addr), .req_wdata(r1_wdata), .req_we(r1_we), .req_size(r1_size),
        .resp_valid(r1_resp_valid), .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Reference model state: memory by word index, when the port frees up, the one pending response
    logic [31:0] mmem [int];
    int          free_at = 0;
    bit          pend    = 1'b0;
    int          resp_at = -1;
    logic [31:0] m_rdata = '0;
    bit          m_err   = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                                     input logic [2:0] sz, output bit err, output logic [31:0] rd);
        int          idx;
        int          off;
        logic [31:0] w, b, h;
        idx = int'((a >> 2) & 32'h3FFF);
        off = int'(a & 32'h3);
        w   = mmem.exists(idx) ? mmem[idx] : 32'h0;
        err = 1'b0;
        rd  = '0;
        if (we != 4'h0) begin
            case (sz[1:0])
                2'd0: w = (w & ~(32'hFF << (8*off))) | ((wd & 32'hFF) << (8*off));
                2'd1: if (off % 2 != 0) err = 1'b1;
                      else w = (w & ~(32'hFFFF << (8*off))) | ((wd & 32'hFFFF) << (8*off));
                2'd2: if (off != 0) err = 1'b1; else w = wd;
                default: err = 1'b1;
            endcase
            if (!err) mmem[idx] = w;
        end else begin
            b = (w >> (8*off)) & 32'hFF;
            h = (w >> (8*off)) & 32'hFFFF;
            case (sz)
                3'd0: rd = (b >= 128) ? b - 32'd256 : b;
                3'd1: if (off % 2 != 0) err = 1'b1; else rd = (h >= 32768) ? h - 32'd65536 : h;
                3'd2: if (off != 0) err = 1'b1; else rd = w;
                3'd4: rd = b;
                3'd5: if (off % 2 != 0) err = 1'b1; else rd = h;
                default: err = 1'b1;
            endcase
        end
    endfunction

    // Model advance at each edge: cycle 'cyc' has just ended
    always @(posedge clk) begin
        bit          e;
        logic [31:0] d;
        if (!reset) begin
            pend    = 1'b0;
            free_at = cyc + 1;
        end else if (req_valid && cyc >= free_at) begin
            model_op(req_addr, req_wdata, req_we, req_size, e, d);
            m_err   = e;
            m_rdata = d;
            pend    = 1'b1;
            resp_at = cyc + (e ? 1 : int'(LAT));
            free_at = resp_at + 1;
        end
        cyc++;
    end

    // Per-cycle compare of every main-instance output against the model
    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = pend && (resp_at == cyc);
            chk("req_ready", 32'(req_ready), 32'(reset && (cyc >= free_at)));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("resp_rdata", resp_rdata, ev ? m_rdata : 32'h0);
            chk("resp_err", 32'(resp_err), 32'(ev && m_err));
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input logic [2:0] sz, output int acc);
        bit done;
        done      = 1'b0;
        acc       = -1;
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_we    = we;
        req_size  = sz;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                acc  = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_we    = 4'($urandom);
        req_size  = 3'($urandom);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: req_ready not seen within 20 cycles");
        end
    endtask

    task automatic get_resp(output logic [31:0] d, output logic e, output int rc, output logic [31:0] md);
        rc = -1;
        d  = '0;
        e  = 1'b0;
        md = '0;
        for (int i = 0; i < 20 && rc < 0; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                d  = resp_rdata;
                e  = resp_err;
                rc = cyc;
                md = m_rdata;
            end
        end
        if (rc < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: resp_valid not seen within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string nm, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic [2:0] sz, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int          acc, rc;
        logic [31:0] d, md;
        logic        e;
        drive(a, wd, we, sz, acc);
        get_resp(d, e, rc, md);
        chk({nm, "_lat"}, 32'(rc - acc), 32'(exp_lat));
        chk({nm, "_rdata"}, d, exp_rd);
        chk({nm, "_err"}, 32'(e), 32'(exp_err));
        chk({nm, "_model"}, md, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, rc, k, off;
        logic [31:0] d, md, a;
        logic        e;

        reset     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h11111111;
        req_we    = 4'hF;
        req_size  = 3'b010;
        r1_valid  = 1'b0;
        r1_addr   = '0;
        r1_wdata  = '0;
        r1_we     = '0;
        r1_size   = '0;

        // Reset held with a request pending: nothing accepted, no response
        repeat (3) begin
            @(posedge clk);
            chk_en = 1'b1;
            @(negedge clk);
            chk("t1_ready_in_reset", 32'(req_ready), 32'h0);
            chk("t1_valid_in_reset", 32'(resp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t1_ready_after_reset", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        get_resp(d, e, rc, md);
        chk("t1_sw_rdata", d, 32'h0);

        txn("t2_sw", 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, 32'h0, 1'b0, 2);
        txn("t2_lw", 32'h10, 32'h0, 4'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);

        txn("t3_lb13", 32'h13, 32'h0, 4'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 2);
        txn("t3_lbu13", 32'h13, 32'h0, 4'h0, 3'b100, 32'h000000DE, 1'b0, 2);
        txn("t3_lh12", 32'h12, 32'h0, 4'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 2);
        txn("t3_lhu12", 32'h12, 32'h0, 4'h0, 3'b101, 32'h0000DEAD, 1'b0, 2);
        txn("t3_lb10", 32'h10, 32'h0, 4'h0, 3'b000, 32'hFFFFFFEF, 1'b0, 2);

        txn("t4_sb11", 32'h11, 32'h12345655, 4'hF, 3'b000, 32'h0, 1'b0, 2);
        txn("t4_sh12", 32'h12, 32'hAAAA7777, 4'hF, 3'b001, 32'h0, 1'b0, 2);
        txn("t4_lw10", 32'h10, 32'h0, 4'h0, 3'b010, 32'h777755EF, 1'b0, 2);

        txn("t5_lw12_err", 32'h12, 32'h0, 4'h0, 3'b010, 32'h0, 1'b1, 1);
        txn("t5_sh13_err", 32'h13, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0, 1'b1, 1);
        txn("t5_lw10", 32'h10, 32'h0, 4'h0, 3'b010, 32'h777755EF, 1'b0, 2);

        // Reset during the wait cycle drops the load
        drive(32'h10, 32'h0, 4'h0, 3'b010, acc);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ready_after_reset", 32'(req_ready), 32'h1);
        chk("t6_no_resp", 32'(resp_valid), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_late_resp", 32'(resp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        txn("t6_lw10", 32'h10, 32'h0, 4'h0, 3'b010, 32'h777755EF, 1'b0, 2);

        // Randomized traffic over a small aliased window
        for (int i = 0; i < 8; i++) begin
            a = {16'($urandom), 16'(32'h200 + 4*i)};
            drive(a, $urandom, 4'hF, 3'b010, acc);
        end
        for (int n = 0; n < 300; n++) begin
            k   = int'($urandom_range(7, 0));
            off = int'($urandom_range(3, 0));
            a   = {16'($urandom), 16'(32'h200 + 4*k + off)};
            drive(a, $urandom, ($urandom_range(1, 0) != 0) ? 4'hF : 4'h0, 3'($urandom), acc);
            if ($urandom_range(29, 0) == 0) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
            end
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        // LATENCY=1 instance: store, then a held load is taken every second cycle
        r1_valid = 1'b1;
        r1_addr  = 32'h20;
        r1_wdata = 32'hCAFEF00D;
        r1_we    = 4'hF;
        r1_size  = 3'b010;
        @(negedge clk);
        chk("t7_sw_ready", 32'(r1_ready), 32'h1);
        @(posedge clk);
        #1;
        r1_valid = 1'b0;
        @(negedge clk);
        chk("t7_sw_resp", 32'(r1_resp_valid), 32'h1);
        chk("t7_sw_err", 32'(r1_resp_err), 32'h0);
        @(posedge clk);
        #1;
        r1_valid = 1'b1;
        r1_addr  = 32'h20;
        r1_we    = 4'h0;
        r1_size  = 3'b010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t7_ready", 32'(r1_ready), 32'(i % 2 == 0));
            chk("t7_valid", 32'(r1_resp_valid), 32'(i % 2 == 1));
            chk("t7_rdata", r1_resp_rdata, (i % 2 == 1) ? 32'hCAFEF00D : 32'h0);
            @(posedge clk);
            #1;
        end
        r1_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
